// File: rtl/uart_frame_packer.sv
// Wraps every PAYLOAD_LEN bytes from a FWFT buffer into SYNC0 SYNC1 LEN [SEQ] payload CSUM frames.
// Define FRAME_SEQ_EN to insert an 8-bit frame sequence byte after LEN.
module uart_frame_packer #(
    parameter int         PAYLOAD_LEN = 16,
    parameter logic [7:0] SYNC0       = 8'hA5,
    parameter logic [7:0] SYNC1       = 8'h5A
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  src_data,
    input  logic        src_valid,
    output logic        src_pop,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int            CW       = $clog2(PAYLOAD_LEN + 1);
    localparam logic [CW-1:0] LEN_CNT  = CW'(PAYLOAD_LEN);
    localparam logic [7:0]    LEN_BYTE = 8'(PAYLOAD_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC0,
        ST_SYNC1,
        ST_LEN,
`ifdef FRAME_SEQ_EN
        ST_SEQ,
`endif
        ST_PAYLOAD,
        ST_CSUM
    } state_t;

    state_t        state, state_nxt;
    logic [7:0]    tx_data_nxt;
    logic          tx_valid_nxt;
    logic          src_pop_nxt;
    logic [7:0]    csum, csum_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [15:0]   frame_cnt_nxt;
    logic          xfer;
    logic          start;
    logic          load_ok;
`ifdef FRAME_SEQ_EN
    logic [7:0]    seq, seq_nxt;
`endif

    assign xfer  = tx_valid && tx_ready;
    assign start = enable && src_valid;
    // src_pop high means the buffer head is still stale this cycle
    assign load_ok = (!tx_valid || xfer) && src_valid && !src_pop && (cnt != LEN_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            src_pop   <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            csum      <= '0;
            cnt       <= '0;
`ifdef FRAME_SEQ_EN
            seq       <= '0;
`endif
        end else begin
            state     <= state_nxt;
            tx_data   <= tx_data_nxt;
            tx_valid  <= tx_valid_nxt;
            src_pop   <= src_pop_nxt;
            busy      <= (state_nxt != ST_IDLE);
            frame_cnt <= frame_cnt_nxt;
            csum      <= csum_nxt;
            cnt       <= cnt_nxt;
`ifdef FRAME_SEQ_EN
            seq       <= seq_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt     = state;
        tx_data_nxt   = tx_data;
        tx_valid_nxt  = tx_valid;
        src_pop_nxt   = 1'b0;
        csum_nxt      = csum;
        cnt_nxt       = cnt;
        frame_cnt_nxt = frame_cnt;
`ifdef FRAME_SEQ_EN
        seq_nxt       = seq;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt    = ST_SYNC0;
                    tx_data_nxt  = SYNC0;
                    tx_valid_nxt = 1'b1;
                    csum_nxt     = '0;
                    cnt_nxt      = '0;
                end
            end
            ST_SYNC0: begin
                if (xfer) begin
                    state_nxt   = ST_SYNC1;
                    tx_data_nxt = SYNC1;
                end
            end
            ST_SYNC1: begin
                if (xfer) begin
                    state_nxt   = ST_LEN;
                    tx_data_nxt = LEN_BYTE;
                end
            end
            ST_LEN: begin
                if (xfer) begin
`ifdef FRAME_SEQ_EN
                    state_nxt   = ST_SEQ;
                    tx_data_nxt = seq;
                    csum_nxt    = csum + seq;
`else
                    state_nxt    = ST_PAYLOAD;
                    tx_valid_nxt = 1'b0;
                    cnt_nxt      = '0;
`endif
                end
            end
`ifdef FRAME_SEQ_EN
            ST_SEQ: begin
                if (xfer) begin
                    state_nxt    = ST_PAYLOAD;
                    tx_valid_nxt = 1'b0;
                    cnt_nxt      = '0;
                end
            end
`endif
            ST_PAYLOAD: begin
                if (xfer && (cnt == LEN_CNT)) begin
                    state_nxt    = ST_CSUM;
                    tx_data_nxt  = csum;
                    tx_valid_nxt = 1'b1;
                end else if (load_ok) begin
                    tx_data_nxt  = src_data;
                    tx_valid_nxt = 1'b1;
                    src_pop_nxt  = 1'b1;
                    csum_nxt     = csum + src_data;
                    cnt_nxt      = cnt + CW'(1);
                end else if (xfer) begin
                    tx_valid_nxt = 1'b0;
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    frame_cnt_nxt = frame_cnt + 16'd1;
`ifdef FRAME_SEQ_EN
                    seq_nxt       = seq + 8'd1;
`endif
                    if (start) begin
                        state_nxt    = ST_SYNC0;
                        tx_data_nxt  = SYNC0;
                        tx_valid_nxt = 1'b1;
                        csum_nxt     = '0;
                        cnt_nxt      = '0;
                    end else begin
                        state_nxt    = ST_IDLE;
                        tx_valid_nxt = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                tx_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Directed bench for uart_frame_packer with PAYLOAD_LEN = 4 and a FWFT buffer model.
module tb_uart_frame_packer;

`ifdef FRAME_SEQ_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [7:0]  src_data = 8'h00;
    logic        src_valid = 1'b0;
    logic        src_pop;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic [15:0] frame_cnt;

    logic [7:0] q[$];
    logic [7:0] rx_data[$];
    int         rx_cyc[$];
    int         cyc = 0;
    int         pop_cnt = 0;
    int         adj_pop = 0;
    int         bad_pop = 0;
    int         stall_err = 0;
    logic       pop_seen = 1'b0;
    logic       prev_pop = 1'b0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_seq = 8'h00;

    uart_frame_packer #(.PAYLOAD_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_pop   (src_pop),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: the popped byte leaves the head shortly after the next edge
    always @(posedge clk) begin
        #2;
        if (pop_seen && q.size() > 0) void'(q.pop_front());
        src_valid <= (q.size() > 0);
        src_data  <= (q.size() > 0) ? q[0] : 8'h00;
    end

    always @(negedge clk) begin
        if (rst) begin
            pop_seen  <= 1'b0;
            prev_pop  <= 1'b0;
            prev_hold <= 1'b0;
        end else begin
            pop_seen <= src_pop;
            prev_pop <= src_pop;
            if (src_pop) pop_cnt <= pop_cnt + 1;
            if (src_pop && prev_pop) adj_pop <= adj_pop + 1;
            if (src_pop && !src_valid) bad_pop <= bad_pop + 1;
            if (prev_hold && !(tx_valid && tx_data == prev_data)) stall_err <= stall_err + 1;
            prev_hold <= tx_valid && !tx_ready;
            prev_data <= tx_data;
            if (tx_valid && tx_ready) begin
                rx_data.push_back(tx_data);
                rx_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k = 0;
        while (rx_data.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        if (rx_data.size() < n) chk({tag, "_timeout"}, rx_data.size(), n);
    endtask

    task automatic wait_pops(input int base, input int n, input int budget, input string tag);
        int k = 0;
        while (pop_cnt - base < n && k < budget) begin
            tick(1);
            k++;
        end
        if (pop_cnt - base < n) chk({tag, "_pop_timeout"}, pop_cnt - base, n);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] csum_base);
        logic [7:0] exp_b[$];
        logic [7:0] got;
        exp_b = {8'hA5, 8'h5A, 8'h04};
`ifdef FRAME_SEQ_EN
        exp_b.push_back(exp_seq);
        csum_base = csum_base + exp_seq;
`endif
        exp_b.push_back(p0);
        exp_b.push_back(p1);
        exp_b.push_back(p2);
        exp_b.push_back(p3);
        exp_b.push_back(csum_base);
        wait_rx(FL, 400, tag);
        for (int i = 0; i < FL; i++) begin
            got = 8'h00;
            if (rx_data.size() > 0) begin
                got = rx_data.pop_front();
                void'(rx_cyc.pop_front());
            end
            chk($sformatf("%s[%0d]", tag, i), got, exp_b[i]);
        end
        exp_seq = exp_seq + 8'd1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err %0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int pb;
        int hold_err;
        int starve_err;
        int k;

        #2;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_src_pop", src_pop, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        tick(2);
        rst = 1'b0;
        tick(2);
        chk("idle_busy", busy, 0);

        // Basic frame
        pb = pop_cnt;
        enable = 1'b1;
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
        check_frame("basic", 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        tick(4);
        chk("basic_pops", pop_cnt - pb, 4);
        chk("basic_frame_cnt", frame_cnt, 1);
        chk("basic_busy", busy, 0);

        // Checksum wrap
        q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'hFF); q.push_back(8'h03);
        check_frame("wrap", 8'hFF, 8'hFF, 8'hFF, 8'h03, 8'h00);
        tick(4);
        chk("wrap_frame_cnt", frame_cnt, 2);

        // Backpressure on SYNC1
        pb = pop_cnt;
        tx_ready = 1'b0;
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
        k = 0;
        while (!tx_valid && k < 20) begin tick(1); k++; end
        chk("bp_sync0_valid", tx_valid, 1);
        chk("bp_sync0_data", tx_data, 8'hA5);
        tx_ready = 1'b1;
        tick(1);
        tx_ready = 1'b0;
        hold_err = 0;
        for (int i = 0; i < 37; i++) begin
            tick(1);
            if (!(tx_valid && tx_data == 8'h5A) || src_pop) hold_err++;
        end
        chk("bp_hold", hold_err, 0);
        chk("bp_no_pop", pop_cnt - pb, 0);
        tx_ready = 1'b1;
        check_frame("bp", 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        tick(4);
        chk("bp_frame_cnt", frame_cnt, 3);

        // Starvation after two bytes, enable dropped during the stall
        pb = pop_cnt;
        q.push_back(8'h01); q.push_back(8'h02);
        wait_pops(pb, 2, 100, "starve");
        wait_rx(FL - 3, 100, "starve_hdr");
        enable = 1'b0;
        starve_err = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (tx_valid || src_pop) starve_err++;
        end
        chk("starve_quiet", starve_err, 0);
        chk("starve_busy", busy, 1);
        q.push_back(8'h03); q.push_back(8'h04);
        check_frame("starve", 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        tick(4);
        chk("starve_frame_cnt", frame_cnt, 4);
        chk("starve_busy_end", busy, 0);

        // Reset mid-payload
        enable = 1'b1;
        pb = pop_cnt;
        q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
        wait_pops(pb, 2, 100, "rstmid");
        rst = 1'b1;
        #1;
        chk("rstmid_tx_valid", tx_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_frame_cnt", frame_cnt, 0);
        q.delete();
        rx_data.delete();
        rx_cyc.delete();
        exp_seq = 8'h00;
        tick(2);
        rst = 1'b0;
        tick(1);
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33); q.push_back(8'h44);
        check_frame("rstmid", 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
        tick(4);
        chk("rstmid_frame_cnt_after", frame_cnt, 1);

        // Back-to-back frames from reset
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_seq = 8'h00;
        tick(1);
        for (int r = 0; r < 2; r++) begin
            q.push_back(8'h01); q.push_back(8'h02); q.push_back(8'h03); q.push_back(8'h04);
        end
        wait_rx(2 * FL, 300, "b2b");
        if (rx_cyc.size() >= FL + 1) chk("b2b_gap", rx_cyc[FL] - rx_cyc[FL-1], 1);
        check_frame("b2b_f0", 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        check_frame("b2b_f1", 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        tick(4);
        chk("b2b_frame_cnt", frame_cnt, 2);
        chk("b2b_busy", busy, 0);

        chk("no_adjacent_pops", adj_pop, 0);
        chk("pop_when_empty", bad_pop, 0);
        chk("hold_stable", stall_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_frame_packer.md
Name: uart_frame_packer

Overview:
- Sits between the selected output buffer and `uart_tx`.
- Pops bytes from a first-word-fall-through buffer and wraps every PAYLOAD_LEN bytes in a frame: SYNC0, SYNC1, LEN, payload, CHECKSUM.
- Drives `uart_tx` with a valid/ready handshake so the host can resynchronise onto the streamed samples.

Parameters:
- PAYLOAD_LEN, 16, payload bytes per frame; legal range 1..255; also transmitted as the LEN byte.
- SYNC0, 8'hA5, first sync byte.
- SYNC1, 8'h5A, second sync byte.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  permits starting a new frame
- src_data  in  8  head byte of the upstream buffer
- src_valid  in  1  upstream buffer non-empty; src_data is valid
- src_pop  out  1  one-cycle pulse that consumes the head byte
- tx_data  out  8  byte presented to `uart_tx`
- tx_valid  out  1  tx_data valid; held until accepted
- tx_ready  in  1  `uart_tx` can accept; a transfer occurs when tx_valid && tx_ready are high on a rising clk edge
- busy  out  1  high whenever the state is not IDLE
- frame_cnt  out  16  completed frames; wraps 0xFFFF -> 0

Behaviour:
- Reset (asynchronous, immediate), applies even mid-frame:
  - state = IDLE; tx_valid = 0; tx_data = 0; src_pop = 0; busy = 0; frame_cnt = 0; checksum = 0; byte counter = 0.
  - Any partial frame is abandoned; no byte already popped is re-sent.
- All outputs are registered.
- States: IDLE, SYNC0, SYNC1, LEN, PAYLOAD, CSUM.
- IDLE:
  - Leave IDLE when enable && src_valid. Next cycle: state = SYNC0, tx_valid = 1, tx_data = SYNC0, checksum cleared.
  - Latency from trigger to first tx_valid: 1 cycle.
- Header (SYNC0, SYNC1, LEN):
  - Each byte is held on tx_data with tx_valid = 1 until transferred.
  - The next header byte is loaded in the same edge as the transfer, so back-to-back bytes are possible when tx_ready stays high.
- Entering PAYLOAD: after the LEN transfer, tx_valid drops to 0.
- PAYLOAD:
  - Load condition: the output register is empty (tx_valid = 0, or being transferred this edge), src_valid = 1, and no pop occurred in the previous cycle.
  - On load: register src_data into tx_data, set tx_valid = 1, pulse src_pop for exactly 1 cycle, add the byte to the checksum (8-bit modulo sum, carries discarded), increment the byte counter.
  - Pop lockout: the 1-cycle lockout after every pop absorbs the registered read latency of the buffer. Consequence: at most one payload byte every 2 cycles.
  - Starvation (src_valid = 0 mid-frame): tx_valid stays 0 and the FSM waits indefinitely. There is no timeout and no padding.
  - After PAYLOAD_LEN bytes are loaded, the last payload transfer moves the FSM to CSUM: tx_data = checksum, tx_valid = 1.
- CSUM:
  - On transfer: frame_cnt += 1 and tx_valid = 0.
  - Then go to IDLE, or go straight to SYNC0 if enable && src_valid, which gives back-to-back frames.
- enable deasserted mid-frame: the current frame completes; only new frame starts are blocked.
- src_pop is never asserted outside PAYLOAD, and never when src_valid = 0.
- tx_data and tx_valid never change while tx_valid = 1 and tx_ready = 0.
- The byte counter is sized to $clog2(PAYLOAD_LEN+1) bits; LEN byte = PAYLOAD_LEN[7:0].

Optional Feature:
- Macro: FRAME_SEQ_EN.
- Defined:
  - Adds a SEQ state between LEN and PAYLOAD that sends an 8-bit sequence number.
  - The sequence number resets to 0, increments on each CSUM transfer, and wraps 0xFF -> 0.
  - SEQ is added into the checksum.
  - Frame length becomes PAYLOAD_LEN + 5.
- Undefined: no SEQ state, no sequence register; frame length = PAYLOAD_LEN + 4.

Test Plan:
- Basic frame: PAYLOAD_LEN = 4, FRAME_SEQ_EN undefined, buffer holds 01 02 03 04, tx_ready tied 1, enable = 1 -> tx bytes A5 5A 04 01 02 03 04 0A; exactly 4 src_pop pulses, none adjacent; frame_cnt = 1; busy returns to 0.
- Checksum wrap: PAYLOAD_LEN = 4, payload FF FF FF 03 -> checksum byte 00.
- Backpressure: tx_ready low for 37 cycles while SYNC1 is presented -> tx_data stays 5A and tx_valid stays 1 throughout; no src_pop; the frame then completes intact.
- Starvation: buffer empties after 2 of 4 bytes -> tx_valid = 0 and src_pop = 0 while empty; writing 03 04 later resumes with checksum 0A; enable dropped during the stall does not abort the frame.
- Reset mid-frame: assert rst during PAYLOAD -> same cycle: tx_valid = 0, busy = 0, frame_cnt = 0; after release with 4 fresh bytes, a full frame starting A5 is sent.
- FRAME_SEQ_EN defined: two back-to-back frames of 01 02 03 04 -> A5 5A 04 00 01 02 03 04 0A, then A5 5A 04 01 01 02 03 04 0B; no idle cycle between frames when tx_ready = 1.
